debounce_sync_gea1: RTL and testbench
=====================================

Name: debounce_sync_gea1

Overview:
- Conditions one asynchronous, possibly bouncing level input (pad, switch, foreign-domain strobe) before it drives generic combinational cells such as nand2/nor2 gates.
- Structure: multi-flop synchronizer, then a debounce counter FSM, then edge-pulse generation.
- Outputs: a clean stable level `y` plus single-cycle rise/fall pulses; downstream gate logic consumes these directly.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal 2..4).
- CNT_W, 4, debounce counter width.
- DB_CYCLES, 10, consecutive stable cycles required to accept a level change (legal 1..2^CNT_W-1).
- RST_VAL, 0, reset value of the synchronizer chain and of `y`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- a  input  1  raw asynchronous input.
- en  input  1  debounce enable; when low, the FSM holds its state and count.
- y  output  1  debounced, synchronized level.
- rise  output  1  one-cycle pulse when `y` goes 0->1.
- fall  output  1  one-cycle pulse when `y` goes 1->0.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Reset (async assert, deassert sampled on clk):
  - sync chain = RST_VAL; y = RST_VAL; rise = fall = busy = 0; cnt = 0.
  - State = ST_HI if RST_VAL = 1, else ST_LO.
- Synchronizer:
  - `a` passes through SYNC_STAGES flops; the last flop is `s`.
  - Only `s` is used downstream; the raw input never reaches the FSM.
- FSM states: ST_LO, CHK_HI, ST_HI, CHK_LO.
  - ST_LO: if en and s = 1, go to CHK_HI with cnt = 1. Otherwise stay.
  - CHK_HI, en high:
    - s = 0: return to ST_LO, cnt = 0 (glitch rejected).
    - s = 1 and cnt = DB_CYCLES-1: go to ST_HI, y = 1, rise = 1 for that one cycle, cnt = 0.
    - Otherwise cnt = cnt+1.
  - ST_HI / CHK_LO: mirror image of ST_LO / CHK_HI; acceptance drives y = 0 and fall = 1.
  - en low in any state: state, cnt and y are held; rise/fall = 0.
- busy = 1 exactly in CHK_HI and CHK_LO.
- Latency:
  - A clean step on `a` reaches `y` after SYNC_STAGES + DB_CYCLES clk edges (SYNC_STAGES to reach `s`, then DB_CYCLES qualifying cycles).
  - rise/fall are registered and assert in the same cycle `y` changes.
- Boundaries:
  - cnt never exceeds DB_CYCLES-1; there is no wrap.
  - DB_CYCLES = 1: acceptance happens on the first CHK cycle with s still valid, so total latency = SYNC_STAGES + 1.
  - s toggling every cycle: y never changes; busy alternates.
  - rise and fall are never high together.
  - rst asserted mid-qualification: immediate return to the reset state; no pulse is emitted.
  - en deasserted mid-qualification and later reasserted: the count resumes from its held value.

Optional Feature:
- Macro: DEBOUNCE_SYNC_GEA1_GLITCH_CNT_EN.
- Defined:
  - Adds output port `gcnt`, 8 bits: a saturating count of rejected candidates (CHK_x -> ST_x returns).
  - Reset value 0; saturates at 255.
  - Cleared on the cycle rise or fall asserts; if a rejection occurs in the same cycle as a clear, the clear wins.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RST_VAL = 0, a = 0, then rst deasserted -> y = 0, rise = fall = busy = 0; these values hold for 20 cycles.
- a steps 0->1 and stays high (defaults) -> busy rises at cycle 3; y = 1 with rise = 1 exactly at edge 12 (2+10); fall stays 0.
- a high for 5 cycles, then back low -> busy high for 5 cycles; y stays 0; no rise; gcnt = 1 when the macro is defined.
- Step to 1; en forced low for 7 cycles mid-qualification; then released -> y goes high at edge 19; cnt resumes without reset.
- rst pulsed high during CHK_HI at count 6 -> y = 0, busy = 0 on the next observation; no rise.
- DB_CYCLES = 1, SYNC_STAGES = 3, a toggled 1->0 with 10 cycles between edges -> each y edge lags the matching a edge by 4 cycles; exactly one rise and one fall.

Source files
------------

// File: rtl/debounce_sync_gea1_if.sv
// Handshake bundle for debounce_sync_gea1: raw level in, clean level and pulses out.
// Optional gcnt field exists only with DEBOUNCE_SYNC_GEA1_GLITCH_CNT_EN defined.
interface debounce_sync_gea1_if;
  logic a;
  logic en;
  logic y;
  logic rise;
  logic fall;
  logic busy;
`ifdef DEBOUNCE_SYNC_GEA1_GLITCH_CNT_EN
  logic [7:0] gcnt;

  modport master (
    output a, en,
    input  y, rise, fall, busy, gcnt
  );

  modport slave (
    input  a, en,
    output y, rise, fall, busy, gcnt
  );
`else
  modport master (
    output a, en,
    input  y, rise, fall, busy
  );

  modport slave (
    input  a, en,
    output y, rise, fall, busy
  );
`endif
endinterface

// File: rtl/debounce_sync_gea1.sv
// Synchronizer + debounce FSM + edge pulses for one asynchronous level input.
// DEBOUNCE_SYNC_GEA1_GLITCH_CNT_EN adds an 8-bit saturating rejected-glitch counter.
module debounce_sync_gea1 #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int DB_CYCLES   = 10,
  parameter bit RST_VAL     = 1'b0
) (
  input logic clk,
  input logic rst,
  debounce_sync_gea1_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LO,
    CHK_HI,
    ST_HI,
    CHK_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               ONE_SHOT = (DB_CYCLES == 1);
  localparam state_t           ST_RST   = RST_VAL ? ST_HI : ST_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      y_q     <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The entry edge out of ST_x counts as the first qualifying cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    reject  = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        ST_LO: begin
          if (s) begin
            if (ONE_SHOT) begin
              state_d = ST_HI;
              y_d     = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = CHK_HI;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_d = ST_LO;
            cnt_d   = '0;
            reject  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HI;
            y_d     = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HI: begin
          if (!s) begin
            if (ONE_SHOT) begin
              state_d = ST_LO;
              y_d     = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = CHK_LO;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHK_LO: begin
          if (s) begin
            state_d = ST_HI;
            cnt_d   = '0;
            reject  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LO;
            y_d     = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.busy = (state_q == CHK_HI) || (state_q == CHK_LO);

`ifdef DEBOUNCE_SYNC_GEA1_GLITCH_CNT_EN
  logic [7:0] gcnt_q;

  // An acceptance clears the count, taking priority over a rejection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= 8'd0;
    end else if (rise_d || fall_d) begin
      gcnt_q <= 8'd0;
    end else if (reject && (gcnt_q != 8'hFF)) begin
      gcnt_q <= gcnt_q + 8'd1;
    end
  end

  assign bus.gcnt = gcnt_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_debounce_sync_gea1.sv
// Self-checking bench for debounce_sync_gea1: vector table, scoreboard queue,
// hand sequences for enable stall, reset abort and a SYNC_STAGES=3/DB_CYCLES=1 instance.
module tb_debounce_sync_gea1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  debounce_sync_gea1_if bus0 ();
  debounce_sync_gea1_if bus1 ();

  debounce_sync_gea1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  debounce_sync_gea1 #(
    .SYNC_STAGES (3),
    .DB_CYCLES   (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic a;
    logic en;
    int   rep;
    logic y;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  typedef struct {
    logic  y;
    logic  rise;
    logic  fall;
    logic  busy;
    string tag;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic a, input logic en, input logic ey,
                       input logic er, input logic ef, input logic eb,
                       input string tag);
    exp_t e;
    bus0.a  = a;
    bus0.en = en;
    sb.push_back('{ey, er, ef, eb, tag});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".y"},    {31'd0, bus0.y},    {31'd0, e.y});
    chk({e.tag, ".rise"}, {31'd0, bus0.rise}, {31'd0, e.rise});
    chk({e.tag, ".fall"}, {31'd0, bus0.fall}, {31'd0, e.fall});
    chk({e.tag, ".busy"}, {31'd0, bus0.busy}, {31'd0, e.busy});
  endtask

  initial begin
    int nrise;
    int nfall;
    checks = 0;
    errors = 0;

    // reset hold
    vt.push_back('{1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0});
    // s toggling every cycle: busy alternates, y never moves
    vt.push_back('{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0});
    // clean rising step: y at edge 12
    vt.push_back('{1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0});
    // clean falling step
    vt.push_back('{1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0});
    vt.push_back('{1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0});

    rst     = 1'b1;
    bus0.a  = 1'b0;
    bus0.en = 1'b1;
    bus1.a  = 1'b0;
    bus1.en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.y",    {31'd0, bus0.y},    32'd0);
    chk("rst.rise", {31'd0, bus0.rise}, 32'd0);
    chk("rst.fall", {31'd0, bus0.fall}, 32'd0);
    chk("rst.busy", {31'd0, bus0.busy}, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      for (int r = 0; r < vt[i].rep; r++) begin
        cycle(vt[i].a, vt[i].en, vt[i].y, vt[i].rise, vt[i].fall,
              vt[i].busy, $sformatf("vec%0d", i));
      end
    end

    // 5-cycle glitch is rejected
    for (int k = 1; k <= 12; k++) begin
      cycle(k <= 5, 1'b1, 1'b0, 1'b0, 1'b0, (k >= 3) && (k <= 7),
            $sformatf("glitch%0d", k));
    end
`ifdef DEBOUNCE_SYNC_GEA1_GLITCH_CNT_EN
    chk("gcnt", {24'd0, bus0.gcnt}, 32'd1);
`endif

    // en low for 7 cycles mid-qualification: y at edge 19
    for (int k = 1; k <= 22; k++) begin
      cycle(1'b1, !((k >= 6) && (k <= 12)), k >= 19, k == 19, 1'b0,
            (k >= 3) && (k <= 18), $sformatf("en%0d", k));
    end
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b1, k < 12, 1'b0, k == 12, (k >= 3) && (k <= 11),
            $sformatf("down%0d", k));
    end

    // reset during CHK_HI at count 6
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, k >= 3,
            $sformatf("pre%0d", k));
    end
    rst = 1'b1;
    #1;
    chk("arst.busy", {31'd0, bus0.busy}, 32'd0);
    chk("arst.y",    {31'd0, bus0.y},    32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("arst.rise", {31'd0, bus0.rise}, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cycle(1'b1, 1'b1, k >= 12, k == 12, 1'b0, (k >= 3) && (k <= 11),
            $sformatf("post%0d", k));
    end

    // SYNC_STAGES=3, DB_CYCLES=1: y lags a by 4 edges
    nrise = 0;
    nfall = 0;
    for (int k = 1; k <= 24; k++) begin
      bus1.a = (k <= 10);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("d1.y%0d", k), {31'd0, bus1.y},
          {31'd0, (k >= 4) && (k <= 13)});
      chk($sformatf("d1.rise%0d", k), {31'd0, bus1.rise}, {31'd0, k == 4});
      chk($sformatf("d1.fall%0d", k), {31'd0, bus1.fall}, {31'd0, k == 14});
      if (bus1.rise) nrise++;
      if (bus1.fall) nfall++;
    end
    chk("d1.nrise", nrise, 32'd1);
    chk("d1.nfall", nfall, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
